// File: rtl/uart_tx_engine.sv
// UART transmitter: baud divider, oversample counter, shift register and
// framing FSM; per-frame data length, parity and stop-bit selection.
module uart_tx_engine #(
  parameter int DATA_MAX   = 9,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_MAX-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [3:0]          data_len,
  input  logic [1:0]          parity_mode,
  input  logic                stop2,
  input  logic [DIV_W-1:0]    baud_div,
  output logic                txd,
  output logic                busy,
  output logic                done
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [3:0] LEN_MIN = 4'd5;
  localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]    baud_q, baud_d;
  logic [SW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          len_q, len_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                txd_q, txd_d;

  logic                tick;
  logic                bit_end;
  logic                last_stop;
  logic                accept;
  logic [3:0]          len_in;
  logic [DATA_MAX-1:0] data_in;
  logic                par_in;
  logic                par_en_in;

  assign tick      = (div_cnt_q == baud_q);
  assign bit_end   = tick && (sample_cnt_q == SAMP_LAST);
  assign last_stop = (state_q == STOP) && bit_end &&
                     (!stop2_q || stop_cnt_q);
  assign tx_ready  = (state_q == IDLE) || last_stop;
  assign accept    = tx_valid && tx_ready;
  assign busy      = (state_q != IDLE);
  assign done      = last_stop;
  assign txd       = txd_q;

  // Frame config as it will be latched on acceptance
  always_comb begin
    len_in = data_len;
    if (data_len < LEN_MIN) begin
      len_in = LEN_MIN;
    end else if (data_len > LEN_MAX) begin
      len_in = LEN_MAX;
    end
    data_in = '0;
    for (int i = 0; i < DATA_MAX; i++) begin
      data_in[i] = tx_data[i] & (4'(i) < len_in);
    end
    par_in    = (^data_in) ^ (parity_mode == 2'b10);
    par_en_in = (parity_mode == 2'b01) ||
                (parity_mode == 2'b10);
  end

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    baud_d       = baud_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    len_d        = len_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    stop2_d      = stop2_q;
    stop_cnt_d   = stop_cnt_q;
    txd_d        = 1'b1;

    if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_d = '0;
        if (sample_cnt_q == SAMP_LAST) begin
          sample_cnt_d = '0;
        end else begin
          sample_cnt_d = sample_cnt_q + SW'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == len_q - 4'(1)) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the STOP exit for back-to-back frames
    if (accept) begin
      state_d      = START;
      div_cnt_d    = '0;
      sample_cnt_d = '0;
      bit_cnt_d    = '0;
      stop_cnt_d   = 1'b0;
      baud_d       = baud_div;
      len_d        = len_in;
      shift_d      = data_in;
      par_en_d     = par_en_in;
      par_bit_d    = par_in;
      stop2_d      = stop2;
    end

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      baud_q       <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      stop_cnt_q   <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      baud_q       <= baud_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      stop2_q      <= stop2_d;
      stop_cnt_q   <= stop_cnt_d;
      txd_q        <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame waveforms from a bit-level model are
// queued at send time and compared clock-by-clock against txd/busy/done.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  data_len;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [15:0] baud_div;
  logic        txd;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .DATA_MAX(9),
    .OVERSAMPLE(16),
    .DIV_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .data_len(data_len),
    .parity_mode(parity_mode),
    .stop2(stop2),
    .baud_div(baud_div),
    .txd(txd),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [15:0] bits;
    int          nb;
    int          bclk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic obs_txd  [1024];
  logic obs_busy [1024];
  logic obs_done [1024];
  logic obs_rdy  [1024];

  function automatic exp_t model(input logic [8:0] d, input int len,
                                 input logic [1:0] pm, input logic s2,
                                 input int div);
    exp_t e;
    int   l;
    int   idx;
    logic p;
    l = (len < 5) ? 5 : ((len > 9) ? 9 : len);
    e.bits = '0;
    p = 1'b0;
    for (int i = 0; i < l; i++) begin
      e.bits[1+i] = d[i];
      p = p ^ d[i];
    end
    idx = 1 + l;
    if (pm == 2'b01 || pm == 2'b10) begin
      e.bits[idx] = (pm == 2'b10) ? ~p : p;
      idx++;
    end
    e.bits[idx] = 1'b1;
    idx++;
    if (s2) begin
      e.bits[idx] = 1'b1;
      idx++;
    end
    e.nb = idx;
    e.bclk = 16 * (div + 1);
    return e;
  endfunction

  task automatic drive_frame(input logic [8:0] d, input int len,
                             input logic [1:0] pm, input logic s2,
                             input int div);
    tx_data     = d;
    data_len    = 4'(len);
    parity_mode = pm;
    stop2       = s2;
    baud_div    = 16'(div);
    tx_valid    = 1'b1;
    sb.push_back(model(d, len, pm, s2, div));
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      obs_txd[i]  = txd;
      obs_busy[i] = busy;
      obs_done[i] = done;
      obs_rdy[i]  = tx_ready;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    data_len = 4'd8;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    baud_div = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1) $display("FAIL rst_txd got %b want 1", txd);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done);
    else n_pass++;
    n_checks++;
    if (tx_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", tx_ready);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_rst got txd=%b busy=%b want 1/0", txd, busy);
    else n_pass++;
  endtask

  task automatic test_single(input string name, input logic [8:0] d,
                             input int len, input logic [1:0] pm,
                             input logic s2, input int div);
    exp_t e;
    int   total;
    int   bad;
    logic want;
    int   busy_cnt;
    int   done_cnt;
    int   done_at;
    int   rdy_bad;
    n_checks++;
    if (tx_ready !== 1'b1)
      $display("FAIL %s_ready_pre got %b want 1", name, tx_ready);
    else n_pass++;
    drive_frame(d, len, pm, s2, div);
    @(negedge clk);
    tx_valid    = 1'b0;
    tx_data     = 9'($urandom);
    data_len    = 4'($urandom);
    parity_mode = 2'($urandom);
    stop2       = ~s2;
    baud_div    = 16'($urandom_range(0, 5));
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s_sb got empty want 1 entry", name);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    total = e.nb * e.bclk;
    observe(total + 4);
    bad = -1;
    want = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    done_at = -1;
    rdy_bad = 0;
    for (int i = 0; i < total + 4; i++) begin
      want = (i < total) ? e.bits[i / e.bclk] : 1'b1;
      if (obs_txd[i] !== want && bad < 0) bad = i;
      if (obs_busy[i] === 1'b1) busy_cnt++;
      if (obs_done[i] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (obs_rdy[i] !== ((i >= total - 1) ? 1'b1 : 1'b0)) rdy_bad++;
    end
    n_checks++;
    if (bad >= 0)
      $display("FAIL %s_txd at clk %0d got %b want %b", name, bad + 1,
               obs_txd[bad], e.bits[bad / e.bclk]);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== total || obs_busy[0] !== 1'b1)
      $display("FAIL %s_busy got %0d clks want %0d", name, busy_cnt, total);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || done_at !== total - 1)
      $display("FAIL %s_done got %0d pulses at clk %0d want 1 at clk %0d",
               name, done_cnt, done_at + 1, total);
    else n_pass++;
    n_checks++;
    if (rdy_bad !== 0)
      $display("FAIL %s_ready got %0d bad clks want 0", name, rdy_bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exp_t e1;
    exp_t e2;
    int   t1;
    int   t2;
    int   bad;
    logic want;
    int   busy_lo;
    int   done_cnt;
    drive_frame(9'h001, 8, 2'b00, 1'b0, 0);
    @(negedge clk);
    tx_data = 9'h080;
    sb.push_back(model(9'h080, 8, 2'b00, 1'b0, 0));
    for (int i = 0; i < 330; i++) begin
      obs_txd[i]  = txd;
      obs_busy[i] = busy;
      obs_done[i] = done;
      obs_rdy[i]  = tx_ready;
      if (i == 160) tx_valid = 1'b0;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    n_checks++;
    if (sb.size() != 2) begin
      $display("FAIL b2b_sb got %0d entries want 2", sb.size());
      sb.delete();
      return;
    end
    n_pass++;
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    t1 = e1.nb * e1.bclk;
    t2 = e2.nb * e2.bclk;
    bad = -1;
    busy_lo = 0;
    done_cnt = 0;
    for (int i = 0; i < 330; i++) begin
      if (i < t1) want = e1.bits[i / e1.bclk];
      else if (i < t1 + t2) want = e2.bits[(i - t1) / e2.bclk];
      else want = 1'b1;
      if (obs_txd[i] !== want && bad < 0) bad = i;
      if (i < t1 + t2 && obs_busy[i] !== 1'b1) busy_lo++;
      if (obs_done[i] === 1'b1) done_cnt++;
    end
    n_checks++;
    if (bad >= 0)
      $display("FAIL b2b_txd at clk %0d got %b", bad + 1, obs_txd[bad]);
    else n_pass++;
    n_checks++;
    if (obs_txd[t1] !== 1'b0)
      $display("FAIL b2b_start2 got %b want 0", obs_txd[t1]);
    else n_pass++;
    n_checks++;
    if (busy_lo !== 0 || obs_busy[t1 + t2] !== 1'b0)
      $display("FAIL b2b_busy got %0d low clks want 0", busy_lo);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 2 || obs_done[t1-1] !== 1'b1 ||
        obs_done[t1+t2-1] !== 1'b1)
      $display("FAIL b2b_done got %0d pulses want 2", done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    drive_frame(9'h000, 8, 2'b00, 1'b0, 0);
    @(negedge clk);
    tx_valid = 1'b0;
    sb.delete();
    repeat (16 * 3 + 5) @(negedge clk);
    n_checks++;
    if (txd !== 1'b0 || busy !== 1'b1)
      $display("FAIL mid_pre got txd=%b busy=%b want 0/1", txd, busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (txd !== 1'b1) $display("FAIL mid_rst_txd got %b want 1", txd);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (tx_ready !== 1'b1)
      $display("FAIL mid_rst_ready got %b want 1", tx_ready);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL mid_rst_done got %b want 0", done);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single("8n1", 9'h0A5, 8, 2'b00, 1'b0, 0);
    test_single("7e1", 9'h055, 7, 2'b01, 1'b0, 2);
    test_single("9o2", 9'h1FF, 9, 2'b10, 1'b1, 0);
    test_back_to_back;
    test_reset_mid;
    test_single("after_rst", 9'h0C3, 8, 2'b01, 1'b1, 1);
    test_single("len3", 9'h0FF, 3, 2'b01, 1'b0, 0);
    test_single("len12", 9'h1A5, 12, 2'b11, 1'b0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
